watch_cu: RTL

- Control unit that sequences the watch/stopwatch time-counter datapath.
- Turns debounced button levels into run/stop, a one-cycle clear, and field-write commands for time setting.
- Runs a small FSM; computes wrapped increment/decrement values from the current hour/min/sec; drives a blink enable for the display.
- Sits between the button debouncers and the time-counter datapath.

---
 rtl/watch_pkg.sv | 49 ++++
 rtl/btn_edge.sv | 22 ++
 rtl/watch_cu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared types, field codes and wrap arithmetic for the watch control unit.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_RUN      = 3'd1,
    ST_CLEAR    = 3'd2,
    ST_SET_HOUR = 3'd3,
    ST_SET_MIN  = 3'd4,
    ST_SET_SEC  = 3'd5
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam int DEF_HOUR_MOD = 24;
  localparam int DEF_MS_MOD   = 60;

  // Step a field by one in either direction, wrapping within [0, modulus-1].
  function automatic logic [5:0] wrap_step(input logic [6:0] value,
                                           input logic [6:0] modulus,
                                           input logic       up);
    logic [6:0] r;
    if (up) begin
      r = (value + 7'd1 >= modulus) ? '0 : value + 7'd1;
    end else begin
      r = (value == '0) ? modulus - 7'd1 : value - 7'd1;
    end
    return 6'(r);
  endfunction

  function automatic logic is_set(input state_t s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    logic [1:0] sel;
    case (s)
      ST_SET_HOUR: sel = SEL_HOUR;
      ST_SET_MIN:  sel = SEL_MIN;
      ST_SET_SEC:  sel = SEL_SEC;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Level-to-pulse detector; history resets to one so a button held through
// reset does not register as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/watch_cu.sv
// Watch/stopwatch control unit: button FSM, field-write generation and blink.
// Optional hold-to-repeat writes are enabled by defining WATCH_CU_AUTOREPEAT_EN.
module watch_cu
  import watch_pkg::*;
#(
  parameter int HOUR_MOD    = DEF_HOUR_MOD,
  parameter int MS_MOD      = DEF_MS_MOD,
  parameter int BLINK_TICKS = 25
`ifdef WATCH_CU_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_100hz,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_set_we,
  output logic [1:0] o_set_sel,
  output logic [5:0] o_set_data,
  output logic       o_blink
);

  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  logic   press_run, press_clear, press_mode, press_up, press_down;
  state_t state, state_n;
  logic   write_req, write_up;
  logic   rep_fire;
  logic [6:0] field, modulus;
  logic [5:0] step;
  logic [BLINK_W-1:0] blink_cnt;

  btn_edge u_run   (.clk(clk), .rst(rst), .btn(i_btn_run),   .press(press_run));
  btn_edge u_clear (.clk(clk), .rst(rst), .btn(i_btn_clear), .press(press_clear));
  btn_edge u_mode  (.clk(clk), .rst(rst), .btn(i_btn_mode),  .press(press_mode));
  btn_edge u_up    (.clk(clk), .rst(rst), .btn(i_btn_up),    .press(press_up));
  btn_edge u_down  (.clk(clk), .rst(rst), .btn(i_btn_down),  .press(press_down));

  always_comb begin
    state_n   = state;
    write_req = 1'b0;
    write_up  = press_up;
    case (state)
      ST_STOP: begin
        if (press_run)        state_n = ST_RUN;
        else if (press_clear) state_n = ST_CLEAR;
        else if (press_mode)  state_n = ST_SET_HOUR;
      end
      ST_RUN: begin
        if (press_run) state_n = ST_STOP;
      end
      ST_CLEAR: state_n = ST_STOP;
      ST_SET_HOUR: begin
        if (press_run)                    state_n = ST_STOP;
        else if (press_mode)              state_n = ST_SET_MIN;
        else if (press_up ^ press_down)   write_req = 1'b1;
      end
      ST_SET_MIN: begin
        if (press_run)                    state_n = ST_STOP;
        else if (press_mode)              state_n = ST_SET_SEC;
        else if (press_up ^ press_down)   write_req = 1'b1;
      end
      ST_SET_SEC: begin
        if (press_run)                    state_n = ST_STOP;
        else if (press_mode)              state_n = ST_STOP;
        else if (press_up ^ press_down)   write_req = 1'b1;
      end
      default: state_n = ST_STOP;
    endcase
    // A held-button repeat only fires when no edge write or state change competes.
    if (rep_fire && !write_req && (state_n == state)) begin
      write_req = 1'b1;
      write_up  = i_btn_up;
    end
  end

  always_comb begin
    case (state)
      ST_SET_HOUR: begin
        field   = {2'b00, i_hour};
        modulus = 7'(HOUR_MOD);
      end
      ST_SET_MIN: begin
        field   = {1'b0, i_min};
        modulus = 7'(MS_MOD);
      end
      default: begin
        field   = {1'b0, i_sec};
        modulus = 7'(MS_MOD);
      end
    endcase
    step = wrap_step(field, modulus, write_up);
  end

`ifdef WATCH_CU_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [RATE_W-1:0] rate_cnt;
  logic              armed;
  logic              hold_lone;

  assign hold_lone = is_set(state) && (i_btn_up ^ i_btn_down);

  always_comb begin
    rep_fire = 1'b0;
    if (hold_lone && i_tick_100hz) begin
      rep_fire = armed ? (rate_cnt == RATE_W'(REPEAT_RATE - 1))
                       : (hold_cnt == HOLD_W'(REPEAT_DELAY - 1));
    end
  end

  // Initial delay phase (hold_cnt) then periodic phase (rate_cnt) once armed.
  always_ff @(posedge clk) begin
    if (!rst || !hold_lone || (state_n != state)) begin
      hold_cnt <= '0;
      rate_cnt <= '0;
      armed    <= 1'b0;
    end else if (i_tick_100hz) begin
      if (armed) begin
        rate_cnt <= rep_fire ? '0 : rate_cnt + 1'b1;
      end else if (rep_fire) begin
        armed    <= 1'b1;
        rate_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_STOP;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      o_set_we   <= 1'b0;
      o_set_sel  <= SEL_NONE;
      o_set_data <= '0;
      o_blink    <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      state      <= state_n;
      o_run_stop <= (state == ST_RUN);
      o_clear    <= (state == ST_CLEAR);
      o_set_sel  <= sel_of(state);
      o_set_we   <= write_req;
      if (write_req) begin
        o_set_data <= step;
      end
      if (!is_set(state) || (state_n != state)) begin
        blink_cnt <= '0;
        o_blink   <= 1'b0;
      end else if (i_tick_100hz) begin
        if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          o_blink   <= ~o_blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
